// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM states, owner ids and access op.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational 2-way round-robin select; on a tie the master that did not win last time is chosen.
module bus_arb_rr_pick
  import bus_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid_c,
  output logic winner_c
);

  always_comb begin
    valid_c  = req0 | req1;
    winner_c = M0;
    if (req0 && req1) begin
      winner_c = ~last_owner;
    end else if (req1) begin
      winner_c = M1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one external memory/IO bus between the CPU (master 0) and an auxiliary master (master 1)
// using a fixed-latency access window and a one-cycle completion acknowledge.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam int unsigned     CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    last_owner_q, last_owner_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  op_e                     op_q, op_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
  logic                    m0_ack_q, m0_ack_d;
  logic                    m1_ack_q, m1_ack_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic                    busy_q, busy_d;
  logic                    pick_valid_c, pick_winner_c;

  bus_arb_rr_pick u_pick (
    .req0       (m0_read | m0_write),
    .req1       (m1_read | m1_write),
    .last_owner (last_owner_q),
    .valid_c    (pick_valid_c),
    .winner_c   (pick_winner_c)
  );

  // Next state; bus outputs are derived from the next-state values so they register cleanly.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d      = ACCESS;
          count_d      = '0;
          owner_d      = pick_winner_c;
          last_owner_d = pick_winner_c;
          if (pick_winner_c == M1) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            op_d    = m1_write ? OP_WRITE : OP_READ;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            op_d    = m0_write ? OP_WRITE : OP_READ;
          end
        end
      end
      ACCESS: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          state_d = DONE;
          if (op_q == OP_READ) begin
            if (owner_q == M1) m1_rdata_d = mem_rdata;
            else               m0_rdata_d = mem_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_read_d  = (state_d == ACCESS) && (op_d == OP_READ);
    mem_write_d = (state_d == ACCESS) && (op_d == OP_WRITE);
    mem_addr_d  = (state_d == ACCESS) ? addr_d : '0;
    mem_wdata_d = mem_write_d ? wdata_d : '0;
    m0_ack_d    = (state_d == DONE) && (owner_d == M0);
    m1_ack_d    = (state_d == DONE) && (owner_d == M1);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_owner_q <= M1;
      owner_q      <= M0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= OP_READ;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
